// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants and types for the instruction-fetch stage.
//   RST_ENABLED      - active level of rst (synchronous reset)
//   DEF_RESET_PC     - default PC after reset
//   DEF_EXC_VECTOR   - default redirect target for an ID-stage exception
//   if_state_e       - fetch FSM state encodings (IF_FETCH / IF_WAIT / IF_FULL)
//   ifid_t           - one IF/ID entry {pc, instr}, also the skid-buffer entry
package fetch_unit_pkg;

    localparam logic        RST_ENABLED    = 1'b1;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0040_0004;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_WAIT  = 2'd1,
        IF_FULL  = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst   - clock / synchronous reset
//   hold       - keep the current entry and valid bit (highest priority)
//   flush      - invalidate the entry (bubble); data keeps its last value
//   load       - capture load_data and mark valid
//   load_data  - entry to capture
//   valid      - entry holds a real instruction
//   data       - current entry
// With none of hold/flush/load asserted the entry goes invalid.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  flush,
    input  logic  load,
    input  ifid_t load_data,
    output logic  valid,
    output ifid_t data
);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (!hold) begin
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
                data  <= load_data;
            end else begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues single-outstanding
// requests to instruction memory and loads the IF/ID register. Acts on the
// ID-stage branch/exception decision by redirecting the PC and squashing
// wrong-path fetches (no delay slot).
//   clk, rst                 - clock / synchronous active-high reset
//   stall                    - hazard unit: hold IF/ID, block redirect
//   is_branch, exception     - ID-stage redirect request (exception wins)
//   branch_target            - ID-stage computed target
//   imem_req, imem_addr      - fetch request (always accepted)
//   imem_rvalid, imem_rdata  - fetch response
//   id_valid, id_pc, id_instr- IF/ID register contents
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        is_branch,
    input  logic        exception,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
);

    if_state_e   state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        squash;
    ifid_t       skid;

    logic        redirect;
    logic [31:0] tgt;
    logic        id_accept;
    logic        ifid_load;
    ifid_t       ifid_load_data;
    ifid_t       ifid_data;

    assign redirect  = id_valid & ~stall & (is_branch | exception);
    assign tgt       = exception ? EXC_VECTOR : branch_target;
    assign id_accept = ~stall | ~id_valid;

    // Request only from FETCH, and never while reset is held so that no
    // response can be in flight when the first post-reset request goes out.
    assign imem_req  = (rst != RST_ENABLED) && (state == IF_FETCH) && !redirect;
    assign imem_addr = pc;

    // IF/ID load source: the live response in WAIT, the skid buffer in FULL.
    always_comb begin
        ifid_load      = 1'b0;
        ifid_load_data = '{pc: req_pc, instr: imem_rdata};
        case (state)
            IF_WAIT: ifid_load = imem_rvalid & ~squash & ~redirect & id_accept;
            IF_FULL: begin
                ifid_load      = ~redirect & ~stall;
                ifid_load_data = skid;
            end
            default: ifid_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLED) begin
            state  <= IF_FETCH;
            pc     <= RESET_PC;
            req_pc <= '0;
            squash <= 1'b0;
            skid   <= '0;
        end else begin
            case (state)
                IF_FETCH: begin
                    if (redirect) begin
                        pc <= tgt;
                    end else begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (imem_rvalid) begin
                        if (squash || redirect) begin
                            // Wrong-path response: drop it.
                            squash <= 1'b0;
                            if (redirect) pc <= tgt;
                            state <= IF_FETCH;
                        end else if (id_accept) begin
                            state <= IF_FETCH;
                        end else begin
                            skid  <= '{pc: req_pc, instr: imem_rdata};
                            state <= IF_FULL;
                        end
                    end else if (redirect) begin
                        // Request still in flight: remember to drop it.
                        squash <= 1'b1;
                        pc     <= tgt;
                    end
                end
                IF_FULL: begin
                    if (redirect) begin
                        pc    <= tgt;
                        state <= IF_FETCH;
                    end else if (!stall) begin
                        state <= IF_FETCH;
                    end
                end
                default: state <= IF_FETCH;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .hold      (stall & id_valid),
        .flush     (redirect),
        .load      (ifid_load),
        .load_data (ifid_load_data),
        .valid     (id_valid),
        .data      (ifid_data)
    );

    assign id_pc    = ifid_data.pc;
    assign id_instr = ifid_data.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by randomized traffic. The
// reference model is architectural: every instruction leaving ID (id_valid &
// ~stall) must be the next one in program order, where program order is
// pc+4 unless that instruction took a branch/exception, and its word must be
// the memory contents at that pc. A bench memory answers each request after
// 1..3 cycles and flags any second outstanding request.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] EXC_PC = 32'h0040_0004;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        is_branch;
    logic        exception;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .is_branch     (is_branch),
        .exception     (exception),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr)
    );

    int          vectors = 0;
    int          miscompares = 0;

    // Bench memory and architectural model state.
    bit          m_out = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_cnt = 0;
    int          m_lat = 1;     // 0 = random 1..3
    bit          inject_stale = 1'b0;
    logic [31:0] exp_pc = RST_PC;
    int          n_cons = 0;
    int          idle = 0;
    int          max_idle = 0;
    bit          req_now, rv_now, rst_now;
    logic [31:0] addr_now;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2001_0005;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_1234 ^ (a << 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // First half of a cycle: drive memory response, then sample at negedge
    // and run the architectural-stream checks.
    task automatic pre();
        if (m_out) m_cnt--;
        if (inject_stale) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = m_out && (m_cnt == 0);
            imem_rdata  = imem_rvalid ? mem_word(m_addr) : $urandom;
        end
        @(negedge clk);
        if (!rst) begin
            if (imem_req) chk("single_outstanding", {31'b0, m_out}, 32'd0);
            if (id_valid && !stall) begin
                chk("stream_pc", id_pc, exp_pc);
                chk("stream_instr", id_instr, mem_word(exp_pc));
                n_cons++;
                idle = 0;
                if (exception)      exp_pc = EXC_PC;
                else if (is_branch) exp_pc = branch_target;
                else                exp_pc = exp_pc + 32'd4;
            end else begin
                idle++;
            end
            if (idle > max_idle) max_idle = idle;
        end
    endtask

    // Second half: record what crossed the edge and advance the memory.
    task automatic post();
        req_now  = imem_req;
        addr_now = imem_addr;
        rv_now   = imem_rvalid;
        rst_now  = rst;
        @(posedge clk);
        #1;
        if (rst_now) begin
            m_out  = 1'b0;
            exp_pc = RST_PC;
            idle   = 0;
        end else begin
            if (rv_now) m_out = 1'b0;
            if (req_now) begin
                m_out  = 1'b1;
                m_addr = addr_now;
                m_cnt  = (m_lat == 0) ? int'($urandom_range(1, 3)) : m_lat;
            end
        end
        inject_stale = 1'b0;
    endtask

    task automatic tick();
        pre();
        post();
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; is_branch = 1'b0; exception = 1'b0;
        branch_target = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);

        // Reset release, 1-cycle memory.
        rst = 1'b0; m_lat = 1;
        pre(); chk("c1_req", {31'b0, imem_req}, 32'd1); chk("c1_addr", imem_addr, RST_PC); post();
        tick();
        chk("c2_valid", {31'b0, id_valid}, 32'd1);
        chk("c2_pc", id_pc, RST_PC);
        chk("c2_instr", id_instr, 32'h2001_0005);

        // Stall for 3 cycles while the next response lands in the skid buffer.
        stall = 1'b1;
        pre(); chk("c3_addr", imem_addr, 32'h0040_0004); chk("c3_req", {31'b0, imem_req}, 32'd1); post();
        tick();
        pre(); chk("full_no_req", {31'b0, imem_req}, 32'd0); post();
        chk("full_hold_pc", id_pc, RST_PC);
        stall = 1'b0;
        tick();
        chk("skid_valid", {31'b0, id_valid}, 32'd1);
        chk("skid_pc", id_pc, 32'h0040_0004);
        chk("skid_instr", id_instr, mem_word(32'h0040_0004));

        // Redirect while waiting on a 3-cycle response.
        stall = 1'b1; m_lat = 3;
        pre(); chk("c7_addr", imem_addr, 32'h0040_0008); post();
        stall = 1'b0; is_branch = 1'b1; branch_target = 32'h0040_0100;
        pre(); chk("wait_no_req", {31'b0, imem_req}, 32'd0); post();
        chk("redir_bubble", {31'b0, id_valid}, 32'd0);
        is_branch = 1'b0;
        tick();
        chk("squash_wait", {31'b0, id_valid}, 32'd0);
        pre(); chk("late_rvalid", {31'b0, imem_rvalid}, 32'd1); post();
        chk("squash_drop", {31'b0, id_valid}, 32'd0);
        m_lat = 1;
        pre(); chk("redir_req", {31'b0, imem_req}, 32'd1); chk("redir_addr", imem_addr, 32'h0040_0100); post();
        tick();
        chk("redir_pc", id_pc, 32'h0040_0100);

        // Exception and branch together: exception vector wins.
        is_branch = 1'b1; exception = 1'b1; branch_target = 32'h0040_0200;
        pre(); chk("exc_no_req", {31'b0, imem_req}, 32'd0); post();
        is_branch = 1'b0; exception = 1'b0;
        pre(); chk("exc_addr", imem_addr, EXC_PC); chk("exc_req", {31'b0, imem_req}, 32'd1); post();
        tick();
        chk("exc_pc", id_pc, EXC_PC);

        // Branch under stall is deferred until the stall clears.
        stall = 1'b1; is_branch = 1'b1; branch_target = 32'h0040_0300;
        pre(); chk("stall_br_addr", imem_addr, 32'h0040_0008); post();
        tick();
        stall = 1'b0;
        pre(); chk("stall_br_no_req", {31'b0, imem_req}, 32'd0); post();
        chk("stall_br_bubble", {31'b0, id_valid}, 32'd0);
        is_branch = 1'b0; m_lat = 3;
        pre(); chk("stall_br_addr2", imem_addr, 32'h0040_0300); post();

        // Reset pulse in WAIT followed by a stale response.
        rst = 1'b1;
        tick();
        chk("rstp_valid", {31'b0, id_valid}, 32'd0);
        chk("rstp_pc", id_pc, 32'd0);
        chk("rstp_instr", id_instr, 32'd0);
        rst = 1'b0; inject_stale = 1'b1; m_lat = 1;
        pre(); chk("rstp_req", {31'b0, imem_req}, 32'd1); chk("rstp_addr", imem_addr, RST_PC); post();
        chk("stale_ignored", {31'b0, id_valid}, 32'd0);
        tick();
        chk("rstp_reload_pc", id_pc, RST_PC);
        chk("rstp_reload_instr", id_instr, 32'h2001_0005);

        // Randomized traffic.
        m_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            is_branch     = ($urandom_range(0, 6) == 0);
            exception     = ($urandom_range(0, 19) == 0);
            branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
                                                        : (32'h0040_0000 | ($urandom & 32'h0000_FFFF));
            tick();
        end
        rst = 1'b0; stall = 1'b0; is_branch = 1'b0; exception = 1'b0;
        chk("progress", {31'b0, n_cons >= 300}, 32'd1);
        chk("max_idle", {31'b0, max_idle <= 48}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
